eq_engine: RTL and testbench
============================

# eq_engine

Pipelined equation datapath for the altitude/battery computations. Evaluates A = (x1·K1) + (x2·K2) or B = (v·t) + c on signed 8-bit operands. A source multiplexer selects between operational inputs and the BIST test-vector bus. It sits directly downstream of the BIST controller's vector outputs and upstream of its result checker.

## Interface
- K1, 3: altitude coefficient for x1 (signed, fits 4 bits)
- K2, 5: altitude coefficient for x2 (signed, fits 4 bits)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operational operand set present this cycle
- x1, x2, v, t, c  in  8 each  operational operands, signed two's complement
- sel_eq  in  1  0 = altitude (A), 1 = battery (B)
- bist_active  in  1  1 = take test bus, ignore operational inputs
- x1_test, x2_test, v_test, t_test, c_test  in  8 each  BIST operands, signed
- sel_eq_test  in  1  BIST equation select
- result_a  out  16  last completed altitude result, signed, held
- result_b  out  16  last completed battery result, signed, held
- out_valid  out  1  one-cycle pulse: a result completed this cycle
- out_sel  out  1  equation of the completing result (valid with out_valid)
- in_dropped  out  1  one-cycle pulse: in_valid arrived while bist_active=1
- op_count  out  16  completed operational (non-BIST) results, saturates at 16'hFFFF

## Operation
- Source mux (combinational): bist_active=1 selects the test bus, with effective valid forced to 1 every cycle. bist_active=0 selects the operational bus, with valid = in_valid.
- Stage S0 (input regs): captures mux output: operands, sel, valid, src tag (= bist_active).
- Stage S1 (multiply):
  - sel=0: p0 = x1·K1 and p1 = x2·K2.
  - sel=1: p0 = v·t and p1 = sign-extended c.
  - All products are signed, 16-bit.
- Stage S2 (add/commit): sum = p0 + p1, 16-bit signed. On a valid entry:
  - sel=0 writes result_a; sel=1 writes result_b.
  - The other result register holds.
  - out_valid=1, out_sel=sel.
  - If src tag=0, op_count increments, saturating.
- Width rule: no overflow is possible.
  - A range is -1024..+1016 for K1=3, K2=5.
  - B range is -16384..+16511.
  - Both fit 16-bit signed. No saturation logic.
- Source switch: bist_q registers bist_active. In any cycle where bist_active != bist_q, S0 and S1 valid bits are cleared on that edge, flushing in-flight entries of the old source. S0 still captures the new source's current operands that same edge. An entry already in S2 commits normally.
- in_dropped=1 in the cycle after in_valid=1 coincides with bist_active=1. The operational set is discarded.
- Reset: synchronous rst=1 sets the following:
  - result_a=0, result_b=0, out_valid=0, out_sel=0, in_dropped=0, op_count=0.
  - All stage valids=0, bist_q=0.
- rst mid-pipeline discards all in-flight entries; nothing commits.

## Timing
- Latency 3: an operand set presented in cycle N (in_valid=1 or bist_active=1) yields out_valid=1 and an updated result register in cycle N+3.
- Throughput: one result per cycle; no backpressure, no stall.
- In BIST mode a new test entry enters every cycle. result_a/result_b track the test vector 3 cycles late, and only the register matching sel_eq_test updates.
- Source switch in cycle N: nothing that entered in N-1 or N-2 commits. The first new-source result appears in N+3.
- out_valid and in_dropped are single-cycle pulses, registered, with no combinational path from inputs.
- The first valid cycle after rst deasserts behaves as cycle N above.

## Test plan
- Reset: drive in_valid=1 with rst=1 for 4 cycles -> all outputs 0, no out_valid. Release -> first out_valid 3 cycles after first in_valid.
- Altitude op: x1=3, x2=4, sel_eq=0, in_valid one cycle -> result_a=29 and out_valid=1 exactly 3 cycles later, out_sel=0. result_b unchanged, op_count=1.
- Battery extremes: back-to-back v=-128,t=-128,c=127 then v=-128,t=127,c=-128 (sel_eq=1) -> result_b=16511, then -16384 on consecutive cycles, op_count +2.
- BIST vectors: bist_active=1 with x1=3,x2=4,sel=0 for 3 cycles, then v=2,t=5,c=16,sel=1 for 5 cycles -> result_a=29, result_b=26, op_count unchanged.
- Source switch / drop:
  - in_valid=1 in cycles N-1 and N, bist_active rises in N -> N-1 entry flushed, N entry discarded with in_dropped=1 in N+1.
  - First test result commits in N+3 with no operational commit.
- Mid-pipeline reset: rst=1 for one cycle while 3 entries are in flight -> no out_valid afterwards, results and op_count return to 0.

Source files
------------

// File: rtl/eq_engine_if.sv
// eq_engine_if: operand/result bundle for eq_engine.
//   master : drives operational + BIST operand buses, observes results
//   slave  : eq_engine side (operands in, results/status out)
//   Operational: in_valid, x1, x2, v, t, c, sel_eq
//   BIST       : bist_active, x1_test, x2_test, v_test, t_test, c_test, sel_eq_test
//   Results    : result_a, result_b, out_valid, out_sel, in_dropped, op_count
interface eq_engine_if;
  logic               in_valid;
  logic signed [7:0]  x1, x2, v, t, c;
  logic               sel_eq;
  logic               bist_active;
  logic signed [7:0]  x1_test, x2_test, v_test, t_test, c_test;
  logic               sel_eq_test;
  logic signed [15:0] result_a, result_b;
  logic               out_valid, out_sel, in_dropped;
  logic [15:0]        op_count;

  modport master (
    output in_valid, x1, x2, v, t, c, sel_eq,
    output bist_active, x1_test, x2_test, v_test, t_test, c_test, sel_eq_test,
    input  result_a, result_b, out_valid, out_sel, in_dropped, op_count
  );

  modport slave (
    input  in_valid, x1, x2, v, t, c, sel_eq,
    input  bist_active, x1_test, x2_test, v_test, t_test, c_test, sel_eq_test,
    output result_a, result_b, out_valid, out_sel, in_dropped, op_count
  );
endinterface

// File: rtl/eq_engine.sv
// eq_engine: 3-stage signed datapath computing A = x1*3 + x2*5 or B = v*t + c.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - eq_engine_if.slave: operand buses (operational / BIST) in,
//          held results, completion pulse, drop pulse, op counter out
// Pipeline: S0 operand regs -> S1 product regs -> S2 sum/commit regs.
module eq_engine (
  input  logic        clk,
  input  logic        rst,
  eq_engine_if.slave  bus
);
  localparam logic signed [15:0] K1 = 16'sd3;
  localparam logic signed [15:0] K2 = 16'sd5;

  function automatic logic signed [15:0] sx(input logic [7:0] a);
    return $signed({{8{a[7]}}, a});
  endfunction

  // Source mux: BIST bus owns the pipe and injects an entry every cycle.
  logic              m_vld, m_sel;
  logic signed [7:0] m_x1, m_x2, m_v, m_t, m_c;
  assign m_vld = bus.bist_active ? 1'b1            : bus.in_valid;
  assign m_sel = bus.bist_active ? bus.sel_eq_test : bus.sel_eq;
  assign m_x1  = bus.bist_active ? bus.x1_test     : bus.x1;
  assign m_x2  = bus.bist_active ? bus.x2_test     : bus.x2;
  assign m_v   = bus.bist_active ? bus.v_test      : bus.v;
  assign m_t   = bus.bist_active ? bus.t_test      : bus.t;
  assign m_c   = bus.bist_active ? bus.c_test      : bus.c;

  logic bist_q;
  logic sw;  // source switch this cycle: kill old-source entries in S0/S1
  assign sw = bus.bist_active != bist_q;

  // S0
  logic              s0_vld_q, s0_sel_q, s0_src_q;
  logic signed [7:0] s0_x1_q, s0_x2_q, s0_v_q, s0_t_q, s0_c_q;

  // S1
  logic               s1_vld_q, s1_sel_q, s1_src_q;
  logic signed [15:0] s1_p0_q, s1_p1_q;
  logic signed [15:0] p0_d, p1_d;
  logic               s1_vld_d;
  assign p0_d     = s0_sel_q ? sx(s0_v_q) * sx(s0_t_q) : sx(s0_x1_q) * K1;
  assign p1_d     = s0_sel_q ? sx(s0_c_q)              : sx(s0_x2_q) * K2;
  assign s1_vld_d = s0_vld_q & ~sw;

  // S2 commit; value ranges fit 16-bit signed, so no saturation needed.
  logic signed [15:0] sum_d, res_a_q, res_b_q;
  logic               commit_d, out_vld_q, out_sel_q, drop_q;
  logic [15:0]        cnt_q, cnt_d;
  assign sum_d    = s1_p0_q + s1_p1_q;
  assign commit_d = s1_vld_q & ~sw;
  assign cnt_d    = (commit_d && !s1_src_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bist_q    <= 1'b0;
      s0_vld_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      out_vld_q <= 1'b0;
      out_sel_q <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bist_q    <= bus.bist_active;
      // S0 always captures the current source, even on a switch edge.
      s0_vld_q  <= m_vld;
      s0_sel_q  <= m_sel;
      s0_src_q  <= bus.bist_active;
      s0_x1_q   <= m_x1;
      s0_x2_q   <= m_x2;
      s0_v_q    <= m_v;
      s0_t_q    <= m_t;
      s0_c_q    <= m_c;
      s1_vld_q  <= s1_vld_d;
      s1_sel_q  <= s0_sel_q;
      s1_src_q  <= s0_src_q;
      s1_p0_q   <= p0_d;
      s1_p1_q   <= p1_d;
      out_vld_q <= commit_d;
      drop_q    <= bus.in_valid & bus.bist_active;
      cnt_q     <= cnt_d;
      if (commit_d) begin
        out_sel_q <= s1_sel_q;
        if (s1_sel_q) res_b_q <= sum_d;
        else          res_a_q <= sum_d;
      end
    end
  end

  assign bus.result_a   = res_a_q;
  assign bus.result_b   = res_b_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.in_dropped = drop_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_eq_engine.sv
// tb_eq_engine: directed + random stimulus for eq_engine against a
// commit-schedule reference model (each accepted entry is booked for the
// cycle it must appear in; source switches and resets cancel bookings).
module tb_eq_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_engine_if bus ();
  eq_engine dut (.clk(clk), .rst(rst), .bus(bus));

  int ncomp = 0;
  int nfail = 0;

  // Reference model state
  bit sv   [4096];
  bit ssel [4096];
  bit ssrc [4096];
  int sval [4096];
  int ra = 0, rb = 0, cnt = 0, n = 0;
  bit eov = 0, eosel = 0, edrop = 0, pbist = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    ncomp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle with the currently driven inputs, then check.
  task automatic cyc();
    int a, b, vv, tt, cc, val;
    bit ev, es;
    if (rst) begin
      for (int k = 1; k <= 3; k++) sv[n+k] = 0;
      ra = 0; rb = 0; cnt = 0; eov = 0; eosel = 0; edrop = 0; pbist = 0;
    end else begin
      if (bus.bist_active != pbist) begin sv[n+1] = 0; sv[n+2] = 0; end
      pbist = bus.bist_active;
      if (bus.bist_active) begin
        ev = 1; es = bus.sel_eq_test;
        a = bus.x1_test; b = bus.x2_test; vv = bus.v_test; tt = bus.t_test; cc = bus.c_test;
      end else begin
        ev = bus.in_valid; es = bus.sel_eq;
        a = bus.x1; b = bus.x2; vv = bus.v; tt = bus.t; cc = bus.c;
      end
      val = es ? vv * tt + cc : a * 3 + b * 5;
      sv[n+3] = ev; ssel[n+3] = es; sval[n+3] = val; ssrc[n+3] = bus.bist_active;
      edrop = bus.in_valid && bus.bist_active;
      eov = sv[n+1];
      if (eov) begin
        eosel = ssel[n+1];
        if (eosel) rb = sval[n+1]; else ra = sval[n+1];
        if (!ssrc[n+1] && cnt < 65535) cnt++;
      end
    end
    @(posedge clk);
    #1;
    n++;
    chk("result_a", bus.result_a, ra);
    chk("result_b", bus.result_b, rb);
    chk("out_valid", bus.out_valid, eov);
    if (eov) chk("out_sel", bus.out_sel, eosel);
    chk("in_dropped", bus.in_dropped, edrop);
    chk("op_count", bus.op_count, cnt);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1; bus.sel_eq = 0;
    bus.x1 = 8'sd7; bus.x2 = 8'sd9; bus.v = 0; bus.t = 0; bus.c = 0;
    bus.bist_active = 0; bus.sel_eq_test = 0;
    bus.x1_test = 0; bus.x2_test = 0; bus.v_test = 0; bus.t_test = 0; bus.c_test = 0;

    // Reset held with in_valid asserted
    repeat (4) cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_op_count", bus.op_count, 0);

    // Altitude op, latency 3
    rst = 0; bus.in_valid = 1; bus.sel_eq = 0; bus.x1 = 8'sd3; bus.x2 = 8'sd4;
    cyc();
    bus.in_valid = 0;
    cyc();
    chk("alt_early", bus.out_valid, 0);
    cyc();
    chk("alt_valid", bus.out_valid, 1);
    chk("alt_a29", bus.result_a, 29);
    chk("alt_b_hold", bus.result_b, 0);
    chk("alt_cnt", bus.op_count, 1);

    // Battery extremes back-to-back
    bus.in_valid = 1; bus.sel_eq = 1;
    bus.v = -8'sd128; bus.t = -8'sd128; bus.c = 8'sd127;
    cyc();
    bus.v = -8'sd128; bus.t = 8'sd127; bus.c = -8'sd128;
    cyc();
    bus.in_valid = 0;
    cyc();
    chk("bat_max", bus.result_b, 16511);
    cyc();
    chk("bat_min", bus.result_b, -16384);
    chk("bat_cnt", bus.op_count, 3);

    // BIST vectors
    bus.bist_active = 1; bus.sel_eq_test = 0; bus.x1_test = 8'sd3; bus.x2_test = 8'sd4;
    repeat (3) cyc();
    bus.sel_eq_test = 1; bus.v_test = 8'sd2; bus.t_test = 8'sd5; bus.c_test = 8'sd16;
    repeat (5) cyc();
    chk("bist_a", bus.result_a, 29);
    chk("bist_b", bus.result_b, 26);
    chk("bist_cnt", bus.op_count, 3);

    // Source switch with drop
    bus.bist_active = 0;
    repeat (4) cyc();
    bus.in_valid = 1; bus.sel_eq = 0; bus.x1 = 8'sd1; bus.x2 = 8'sd1;
    cyc();
    bus.bist_active = 1; bus.sel_eq_test = 0; bus.x1_test = 8'sd5; bus.x2_test = 8'sd0;
    cyc();
    chk("sw_drop", bus.in_dropped, 1);
    bus.in_valid = 0;
    cyc();
    chk("sw_flush", bus.out_valid, 0);
    cyc();
    chk("sw_first", bus.out_valid, 1);
    chk("sw_a15", bus.result_a, 15);
    chk("sw_cnt", bus.op_count, 3);

    // Mid-pipeline reset
    bus.bist_active = 0; bus.in_valid = 1; bus.sel_eq = 0; bus.x1 = 8'sd10; bus.x2 = 8'sd10;
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0; bus.in_valid = 0;
    repeat (4) cyc();
    chk("mrst_a", bus.result_a, 0);
    chk("mrst_cnt", bus.op_count, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) bus.bist_active = ~bus.bist_active;
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.sel_eq = $urandom_range(0, 1);
      bus.x1 = 8'($urandom); bus.x2 = 8'($urandom);
      bus.v = 8'($urandom); bus.t = 8'($urandom); bus.c = 8'($urandom);
      bus.sel_eq_test = $urandom_range(0, 1);
      bus.x1_test = 8'($urandom); bus.x2_test = 8'($urandom);
      bus.v_test = 8'($urandom); bus.t_test = 8'($urandom); bus.c_test = 8'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
